// File: rtl/imm_rot_encoder_if.sv
// Request/result bundle for the rotated-immediate encoder.
// The requester drives start/value and the encoder returns busy/done and the 12-bit field.
interface imm_rot_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic [7:0]  imm8;
  logic [3:0]  rot;
  logic [11:0] encoding;

  modport master (
    output start, value,
    input  busy, done, valid, imm8, rot, encoding
  );

  modport slave (
    input  start, value,
    output busy, done, valid, imm8, rot, encoding
  );
endinterface

// File: rtl/imm_rot_encoder.sv
// Finds the lowest rot with value == imm8 ror 2*rot by testing one rotation per cycle (1..16 cycles).
// No backpressure: start is sampled only in IDLE, and results are held until the next done pulse.
module imm_rot_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROT    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_rot_encoder_if.slave bus
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [3:0] LAST_ROT = 4'(NUM_ROT - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [7:0]            imm8_q, imm8_d;
  logic [3:0]            rot_q, rot_d;

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] cand;
  logic                  hit;

  // Rotating the constant left by 2*cnt undoes an imm8 ror 2*cnt; a shift by 32 yields 0,
  // so the cnt=0 candidate is the value itself.
  always_comb begin
    shamt = {cnt_q, 1'b0};
    cand  = (val_q << shamt) | (val_q >> (6'(DATA_WIDTH) - {1'b0, shamt}));
    hit   = (cand[DATA_WIDTH-1:8] == '0);
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    imm8_d  = imm8_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d   = bus.value;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          imm8_d  = cand[7:0];
          rot_d   = cnt_q;
          valid_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == LAST_ROT) begin
          imm8_d  = 8'd0;
          rot_d   = 4'd0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      imm8_q  <= 8'd0;
      rot_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      imm8_q  <= imm8_d;
      rot_q   <= rot_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;
  assign bus.imm8     = imm8_q;
  assign bus.rot      = rot_q;
  assign bus.encoding = {rot_q, imm8_q};

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Self-checking bench for imm_rot_encoder: directed cases, random values against a brute-force model,
// ignored start while busy, start on done, and reset abort.
module tb_imm_rot_encoder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  imm_rot_encoder_if bus ();

  imm_rot_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: enumerate every (rot, imm8) pair in increasing rot order and return the first
  // whose imm8 rotated right by 2*rot reproduces the value.
  function automatic void ref_encode(input logic [31:0] v, output logic ok,
                                     output logic [3:0] r, output logic [7:0] i);
    logic [63:0] w;
    ok = 1'b0;
    r  = 4'd0;
    i  = 8'd0;
    for (int rr = 0; rr < 16 && !ok; rr++) begin
      for (int ii = 0; ii < 256 && !ok; ii++) begin
        w = {24'd0, 8'(ii), 24'd0, 8'(ii)} >> (2 * rr);
        if (w[31:0] == v) begin
          ok = 1'b1;
          r  = 4'(rr);
          i  = 8'(ii);
        end
      end
    end
  endfunction

  // Issues one start and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_search(input logic [31:0] v, input bit scramble, output int lat,
                            output logic vld, output logic [3:0] r, output logic [7:0] i8,
                            output logic [11:0] enc, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_ok = (bus.busy === 1'b1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (scramble) bus.value = $urandom;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (lat >= 0 && bus.busy !== 1'b0) busy_ok = 1'b0;
    vld = bus.valid;
    r   = bus.rot;
    i8  = bus.imm8;
    enc = bus.encoding;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.value = 32'd0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.valid, bus.imm8, bus.rot, bus.encoding} !== 27'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b imm8=%h rot=%h enc=%h, want all 0",
               bus.busy, bus.done, bus.valid, bus.imm8, bus.rot, bus.encoding);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [31:0] vals [6] = '{32'h0000_00FF, 32'hF000_000F, 32'hFF00_0000,
                              32'h0000_0000, 32'h0000_0102, 32'h0000_03FC};
    logic [12:0] exp  [6] = '{{1'b1, 4'd0, 8'hFF}, {1'b1, 4'd2, 8'hFF}, {1'b1, 4'd4, 8'hFF},
                              {1'b1, 4'd0, 8'h00}, {1'b0, 4'd0, 8'h00}, {1'b1, 4'd15, 8'hFF}};
    int          lats [6] = '{1, 3, 5, 1, 16, 16};
    int lat; logic vld; logic [3:0] r; logic [7:0] i8; logic [11:0] enc; bit bok;
    for (int k = 0; k < 6; k++) begin
      run_search(vals[k], 1'b0, lat, vld, r, i8, enc, bok);
      n_checks++;
      if (lat !== lats[k])
        $display("FAIL dir_latency[%h]: got %0d, want %0d", vals[k], lat, lats[k]);
      else n_pass++;
      n_checks++;
      if ({vld, r, i8} !== exp[k])
        $display("FAIL dir_result[%h]: got valid=%b rot=%0d imm8=%h, want %h",
                 vals[k], vld, r, i8, exp[k]);
      else n_pass++;
      n_checks++;
      if (enc !== exp[k][11:0])
        $display("FAIL dir_encoding[%h]: got %h, want %h", vals[k], enc, exp[k][11:0]);
      else n_pass++;
      n_checks++;
      if (!bok) $display("FAIL dir_busy[%h]: got busy profile wrong, want high until done", vals[k]);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done !== 1'b0) $display("FAIL dir_done_pulse[%h]: got done=%b, want 0", vals[k], bus.done);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int lat; logic vld; logic [3:0] r; logic [7:0] i8; logic [11:0] enc; bit bok;
    logic ev; logic [3:0] er; logic [7:0] ei; logic [31:0] v; logic [63:0] w;
    int elat;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        w = {24'd0, 8'($urandom_range(0, 255)), 24'd0, 8'd0};
        w[7:0] = w[39:32];
        w = w >> (2 * $urandom_range(0, 15));
        v = w[31:0];
      end else begin
        v = $urandom;
      end
      ref_encode(v, ev, er, ei);
      elat = ev ? int'(er) + 1 : 16;
      run_search(v, 1'b1, lat, vld, r, i8, enc, bok);
      n_checks++;
      if (lat !== elat) $display("FAIL rnd_latency[%h]: got %0d, want %0d", v, lat, elat);
      else n_pass++;
      n_checks++;
      if ({vld, r, i8, enc} !== {ev, er, ei, er, ei})
        $display("FAIL rnd_result[%h]: got valid=%b rot=%0d imm8=%h enc=%h, want valid=%b rot=%0d imm8=%h",
                 v, vld, r, i8, enc, ev, er, ei);
      else n_pass++;
      n_checks++;
      if (!bok) $display("FAIL rnd_busy[%h]: got busy profile wrong, want high until done", v);
      else n_pass++;
    end
    bus.value = 32'd0;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h0000_0102;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == 2);
      if (c == 2) bus.value = 32'h0000_00FF;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat !== 16) $display("FAIL ignore_start_latency: got %0d, want 16", lat);
    else n_pass++;
    n_checks++;
    if ({bus.valid, bus.encoding} !== 13'd0)
      $display("FAIL ignore_start_result: got valid=%b enc=%h, want 0 000", bus.valid, bus.encoding);
    else n_pass++;
    bus.start = 1'b1;
    bus.value = 32'h0000_00FF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.valid, bus.encoding} !== {1'b1, 1'b0, 1'b0, 12'h000})
      $display("FAIL start_on_done_accept: got busy=%b done=%b valid=%b enc=%h, want 1 0 0 000",
               bus.busy, bus.done, bus.valid, bus.encoding);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.done, bus.valid, bus.rot, bus.imm8} !== {1'b1, 1'b1, 4'd0, 8'hFF})
      $display("FAIL start_on_done_result: got done=%b valid=%b rot=%0d imm8=%h, want 1 1 0 ff",
               bus.done, bus.valid, bus.rot, bus.imm8);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int lat; logic vld; logic [3:0] r; logic [7:0] i8; logic [11:0] enc; bit bok;
    bit quiet;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 32'h0000_0102;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.valid, bus.imm8, bus.rot, bus.encoding} !== 27'd0)
      $display("FAIL abort_outputs: got busy=%b done=%b valid=%b imm8=%h rot=%h enc=%h, want all 0",
               bus.busy, bus.done, bus.valid, bus.imm8, bus.rot, bus.encoding);
    else n_pass++;
    quiet = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) rst_n = 1'b1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL abort_no_done: got done/busy activity after abort, want none");
    else n_pass++;
    run_search(32'h0000_03FC, 1'b0, lat, vld, r, i8, enc, bok);
    n_checks++;
    if ({lat == 16, vld, r, i8, enc} !== {1'b1, 1'b1, 4'd15, 8'hFF, 12'hFFF})
      $display("FAIL abort_recover: got lat=%0d valid=%b rot=%0d imm8=%h enc=%h, want 16 1 15 ff fff",
               lat, vld, r, i8, enc);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_rot_encoder.md
Name: imm_rot_encoder

Overview:
- Inverse of the operand-2 rotate/shift decode path: takes a 32-bit constant and searches for the ARM-style rotated-immediate encoding, where value = imm8 rotated right by 2*rot.
- Tests one rotation candidate per clock, so the search is 1 to 16 cycles long.
- Sits beside the datapath and is used by the instruction-build and self-check logic to produce 12-bit operand-2 immediate fields.
- Uses a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 32, width of the constant to encode. Only 32 is supported.
- NUM_ROT, 16, number of rotation candidates. The rotation step is fixed at 2 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a search. Sampled only in IDLE.
- value  input  32  constant to encode. Latched on an accepted start.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when the result outputs update.
- valid  output  1  1 = encodable. Meaningful from the done pulse onward.
- imm8  output  8  8-bit immediate of the encoding.
- rot  output  4  rotation field. The actual rotate-right amount is 2*rot.
- encoding  output  12  {rot, imm8}.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, valid=0; imm8, rot, encoding=0.
  - Internal latched value and counter are cleared.
  - Reset during SEARCH aborts the search immediately; no done pulse follows.
- States: IDLE, SEARCH.
- IDLE:
  - On a clock edge with start=1: latch value, set cnt=0, go to SEARCH, set busy=1.
  - Result outputs keep their previous values.
- SEARCH, each cycle:
  - cand = latched value rotated LEFT by 2*cnt, computed combinationally with wrap-around.
  - If cand[31:8]==0: at the next edge set imm8=cand[7:0], rot=cnt, valid=1, done=1, busy=0, go to IDLE.
  - Else if cnt==15: at the next edge set valid=0, imm8=0, rot=0, done=1, busy=0, go to IDLE.
  - Else: cnt=cnt+1 and stay in SEARCH.
- Selection rule: the lowest matching rot wins, so the result is deterministic (e.g. value 0 gives rot=0, imm8=0).
- Latency:
  - The edge that accepts start is E0.
  - A match at candidate k asserts done after edge E(k+1), i.e. k+1 cycles.
  - The not-encodable result asserts done after E16, i.e. 16 cycles.
- done is high for exactly one cycle. valid, imm8, rot and encoding hold until the next result or reset.
- encoding = {rot, imm8} at all times.
- start while busy=1 is ignored; the value input is not re-sampled.
- start in the cycle done is high (state already IDLE) is accepted. busy rises after that edge while the old results stay held.
- Changes on value after acceptance do not affect the search in progress.
- Arithmetic:
  - The rotation amount 2*cnt is 5 bits, 0..30. Rotation is modulo 32 and no bits are lost.
  - Odd rotations are never generated.

Test Plan:
- value=0x000000FF, start pulse -> busy high 1 cycle; done 1 cycle after E0; valid=1, rot=0, imm8=0xFF, encoding=0x0FF.
- value=0xF000000F -> done 3 cycles after E0; valid=1, rot=2, imm8=0xFF, encoding=0x2FF.
- value=0xFF000000 -> done 5 cycles after E0; valid=1, rot=4, imm8=0xFF. value=0x00000000 -> rot=0, imm8=0x00, valid=1 after 1 cycle.
- value=0x00000102 (odd-rotation span) -> busy for 16 cycles; done after E16; valid=0, imm8=0, rot=0.
- Start 0x00000102, re-assert start with value=0x000000FF at cycle 3 -> ignored; result is still valid=0 at cycle 16. Then start with done high -> accepted, and the next result is rot=0, imm8=0xFF.
- Start 0x00000102, drive rst_n=0 at cycle 5 between edges -> busy, done, valid and all outputs go to 0 immediately, with no done pulse. After release, a start with 0x000003FC gives rot=15, imm8=0xFF, done 16 cycles after E0.
